// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive FSM with 3-sample majority voting; parity support under UART_RX_PARITY_SUPPORT_EN
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            EDGE_COUNT,
    input  logic [3:0]            BIT_COUNT,
    output logic                  EN,
    output logic                  COUNT_RST,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

`ifdef UART_RX_PARITY_SUPPORT_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic [2:0]            samp_q, samp_d;

    logic [5:0] edge6;
    logic [5:0] half;
    logic       prescale_ok;
    logic       end_of_bit;
    logic       sampled;

    assign edge6       = {1'b0, EDGE_COUNT};
    assign half        = {1'b0, PRESCALE[5:1]};
    assign prescale_ok = (PRESCALE == 6'd8) || (PRESCALE == 6'd16) || (PRESCALE == 6'd32);
    assign end_of_bit  = (edge6 == PRESCALE - 6'd1);
    assign sampled     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (prescale_ok && !RX_IN) state_d = S_START;
            S_START:  if (end_of_bit) state_d = sampled ? S_IDLE : S_DATA;
            S_DATA: begin
                if (end_of_bit && (BIT_COUNT == LAST_BIT)) begin
`ifdef UART_RX_PARITY_SUPPORT_EN
                    state_d = PAR_EN ? S_PARITY : S_STOP;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_SUPPORT_EN
            S_PARITY: if (end_of_bit) state_d = S_STOP;
`endif
            S_STOP:   if (end_of_bit) state_d = S_DONE;
            S_DONE:   state_d = RX_IN ? S_IDLE : S_START;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        EN         = 1'b1;
        COUNT_RST  = !((state_q == S_IDLE) || (state_q == S_DONE));
        DATA_VALID = (state_q == S_DONE) && !par_err_q && !stp_err_q;
    end

    // Mid-bit sampling, decisions at end-of-bit; error flags are sticky until the next start
    always_comb begin
        samp_d    = samp_q;
        p_data_d  = p_data_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        if (state_q != S_IDLE) begin
            if (edge6 == half - 6'd1) samp_d[0] = RX_IN;
            if (edge6 == half)        samp_d[1] = RX_IN;
            if (edge6 == half + 6'd1) samp_d[2] = RX_IN;
        end
        if ((state_d == S_START) && (state_q != S_START)) begin
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end
        if (end_of_bit) begin
            case (state_q)
                S_DATA:   p_data_d = {sampled, p_data_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_SUPPORT_EN
                S_PARITY: if (sampled != ((^p_data_q) ^ PAR_TYP)) par_err_d = 1'b1;
`endif
                S_STOP:   if (!sampled) stp_err_d = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_q  <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            samp_q    <= 3'b111;
        end else begin
            p_data_q  <= p_data_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            samp_q    <= samp_d;
        end
    end

    assign P_DATA  = p_data_q;
    assign PAR_ERR = par_err_q;
    assign STP_ERR = stp_err_q;

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, number of data bits per frame; legal range 5..8.
REQ-002 SHALL have port: CLK  input  1  receive oversampling clock; all state on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: RX_IN  input  1  serial line, idle high, LSB first.
REQ-005 SHALL have port: PRESCALE  input  6  oversampling ratio; legal 8, 16, 32.
REQ-006 SHALL have port: PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: EDGE_COUNT  input  5  edge index within current bit, from the edge/bit counter.
REQ-009 SHALL have port: BIT_COUNT  input  4  bit index within frame (0 = start), from the edge/bit counter.
REQ-010 SHALL have port: EN  output  1  counter enable.
REQ-011 SHALL have port: COUNT_RST  output  1  counter clear, active-low (counter clears when EN=1 and COUNT_RST=0).
REQ-012 SHALL have port: P_DATA  output  DATA_WIDTH  last received data word.
REQ-013 SHALL have port: DATA_VALID  output  1  one-CLK pulse, P_DATA holds an error-free word.
REQ-014 SHALL have port: PAR_ERR  output  1  parity mismatch on current/last frame.
REQ-015 SHALL have port: STP_ERR  output  1  stop bit sampled low on current/last frame.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-017 SHALL drive EN=1 in every state; COUNT_RST=0 in IDLE and DONE, 1 otherwise; both decoded from state only.
REQ-018 SHALL sample RX_IN into three registers at EDGE_COUNT = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1; sampled bit = 2-of-3 majority, held until next bit's samples.
REQ-019 SHALL define end-of-bit as EDGE_COUNT = PRESCALE-1; all bit decisions occur at end-of-bit.
REQ-020 IDLE: RX_IN=0 and PRESCALE legal -> START; PRESCALE illegal -> remain IDLE regardless of RX_IN.
REQ-021 START: entry clears PAR_ERR and STP_ERR; at end-of-bit sampled bit 0 -> DATA, sampled bit 1 (glitch) -> IDLE.
REQ-022 DATA: at end-of-bit shift sampled bit into P_DATA MSB, shifting right (LSB-first order); at end-of-bit with BIT_COUNT = DATA_WIDTH -> PARITY if PAR_EN=1 else STOP.
REQ-023 PARITY: expected bit = XOR of P_DATA, inverted when PAR_TYP=1; at end-of-bit set PAR_ERR=1 on mismatch; -> STOP always.
REQ-024 STOP: at end-of-bit set STP_ERR=1 if sampled bit 0; -> DONE always.
REQ-025 DONE: lasts exactly one CLK; DATA_VALID=1 in that cycle iff PAR_ERR=0 and STP_ERR=0; next state START if RX_IN=0 (back-to-back frame), else IDLE.
REQ-026 DATA_VALID SHALL be 0 in every state other than DONE.
REQ-027 P_DATA SHALL hold its value from DONE until the next frame's first data bit shift.
REQ-028 PAR_EN, PAR_TYP, PRESCALE changes mid-frame: behaviour unspecified; sampled at each use.

Reset
REQ-029 On RST low: state IDLE, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, sample registers=1; EN=1, COUNT_RST=0 by decode.
REQ-030 RST asserted mid-frame SHALL abort the frame with no DATA_VALID; the next start edge after release SHALL be received normally.

Configuration
REQ-031 Macro UART_RX_PARITY_SUPPORT_EN defined: PAR_EN/PAR_TYP honoured, PARITY state present as above.
REQ-032 Macro undefined: PARITY state absent, DATA -> STOP always, PAR_EN and PAR_TYP ignored, PAR_ERR tied 0.

Verification
REQ-033 PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 parity 0 stop 1 -> P_DATA=0xA5, DATA_VALID one CLK, PAR_ERR=0, STP_ERR=0.
REQ-034 Same frame with parity bit 1 -> PAR_ERR=1, DATA_VALID stays 0; PAR_TYP=1 with parity 1 -> DATA_VALID pulse.
REQ-035 PRESCALE=16, PAR_EN=0, frame 0x3C with stop bit 0 -> STP_ERR=1, no DATA_VALID, next good frame clears STP_ERR.
REQ-036 PRESCALE=16, RX_IN low for 2 CLK then high -> return to IDLE after one bit time, no DATA_VALID, no error flags.
REQ-037 PRESCALE=32, frames 0x01 then 0xFF with zero idle between -> two DATA_VALID pulses, P_DATA=0x01 then 0xFF.
REQ-038 RST pulsed low during DATA bit 4 -> all outputs reset values; following frame 0x5A received correctly.
